seg_disp_sched: RTL

SEG_DISP_SCHED -- requirements
Module: seg_disp_sched

---
 rtl/seg_disp_sched_pkg.sv | 36 +++
 rtl/seg_disp_sched_blink.sv | 54 +++++
 rtl/seg_disp_sched.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seg_disp_sched_pkg.sv
// Shared types and helpers for the segment display scheduler.
// Holds the FSM encoding, requester indices and the arbitration rule.
package seg_disp_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_e;

   localparam logic [1:0] REQ_ALERT = 2'd0;
   localparam logic [1:0] REQ_ONE   = 2'd1;
   localparam logic [1:0] REQ_TWO   = 2'd2;

   // Alert always wins; a 1/2 tie goes to the one not granted last.
   // Only meaningful when at least one req bit is set.
   function automatic logic [1:0] arb_pick(
      input logic [2:0] req,
      input logic       last_two
   );
      logic [1:0] w;
      if (req[0])
         w = REQ_ALERT;
      else if (req[1] && req[2])
         w = last_two ? REQ_ONE : REQ_TWO;
      else if (req[1])
         w = REQ_ONE;
      else
         w = REQ_TWO;
      return w;
   endfunction

   function automatic logic [2:0] onehot(input logic [1:0] idx);
      return 3'b001 << idx;
   endfunction

endpackage

// File: rtl/seg_disp_sched_blink.sv
// seg_blink_timer: toggles phase every BLINK_CYC enabled cycles.
// Ports: clk, rst (async high), clr (restart), en (count), phase (1 = blanked).
module seg_blink_timer #(
   parameter int unsigned BLINK_CYC = 12500000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic phase
);

   localparam int CW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_CYC - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;

   // The state loaded on clr already counts the grant cycle itself, so
   // phase runs one cycle ahead and lines up with the registered dig_en.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (clr) begin
         if (BLINK_CYC == 1) begin
            cnt_d   = '0;
            phase_d = 1'b1;
         end else begin
            cnt_d   = CW'(1);
            phase_d = 1'b0;
         end
      end else if (en) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/seg_disp_sched.sv
// Arbitrates three display requesters onto one 7-segment scanner.
// Ports: clk, rst, req/data*/mask*/blink in; grant, disp_num, dig_en out.
module seg_disp_sched
   import seg_disp_sched_pkg::*;
#(
   parameter int unsigned HOLD_CYC  = 50000000,
   parameter int unsigned BLINK_CYC = 12500000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [15:0] data0,
   input  logic [15:0] data1,
   input  logic [15:0] data2,
   input  logic [3:0]  mask0,
   input  logic [3:0]  mask1,
   input  logic [3:0]  mask2,
   input  logic [2:0]  blink,
   output logic [2:0]  grant,
   output logic [15:0] disp_num,
   output logic [3:0]  dig_en
);

   localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC - 1);

   state_e        state_q, state_d;
   logic [2:0]    grant_q, grant_d;
   logic [1:0]    gidx_q, gidx_d;
   logic [15:0]   disp_q, disp_d;
   logic [3:0]    dig_q, dig_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          last_two_q, last_two_d;

   logic          take;
   logic          drop;
   logic [1:0]    pick;
   logic [1:0]    win;
   logic [1:0]    sel;
   logic [15:0]   data_sel;
   logic [3:0]    mask_sel;
   logic          phase;

   seg_blink_timer #(
      .BLINK_CYC(BLINK_CYC)
   ) u_blink (
      .clk  (clk),
      .rst  (rst),
      .clr  (take),
      .en   (state_q == SHOW),
      .phase(phase)
   );

   always_comb begin
      take = 1'b0;
      drop = 1'b0;
      pick = arb_pick(req, last_two_q);
      win  = gidx_q;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               take = 1'b1;
               win  = pick;
            end
         end
         SHOW: begin
            if (req[0] && gidx_q != REQ_ALERT) begin
               take = 1'b1;
               win  = REQ_ALERT;
            end else if (!req[gidx_q]) begin
               if (|req) begin
                  take = 1'b1;
                  win  = pick;
               end else begin
                  drop = 1'b1;
               end
            end else if (hold_q == HOLD_MAX) begin
               // Holder is still in req, so it only keeps the grant
               // when nobody else can beat it.
               take = (pick != gidx_q);
               win  = pick;
            end
         end
         default: ;
      endcase
   end

   assign sel = take ? win : gidx_q;

   always_comb begin
      data_sel = data0;
      mask_sel = mask0;
      unique case (sel)
         REQ_ONE: begin
            data_sel = data1;
            mask_sel = mask1;
         end
         REQ_TWO: begin
            data_sel = data2;
            mask_sel = mask2;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      disp_d     = disp_q;
      dig_d      = dig_q;
      hold_d     = hold_q;
      last_two_d = last_two_q;
      if (take) begin
         state_d = SHOW;
         gidx_d  = win;
         grant_d = onehot(win);
         hold_d  = '0;
         if (win != REQ_ALERT)
            last_two_d = (win == REQ_TWO);
      end else if (drop) begin
         state_d = IDLE;
         grant_d = 3'b000;
         hold_d  = '0;
      end else if (state_q == SHOW && hold_q != HOLD_MAX) begin
         hold_d = hold_q + 1'b1;
      end
      if (state_d == SHOW) begin
         disp_d = data_sel;
         dig_d  = mask_sel & ~{4{blink[sel] & phase & ~take}};
      end else begin
         dig_d  = 4'b0000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= 3'b000;
         gidx_q     <= REQ_ALERT;
         disp_q     <= 16'h0000;
         dig_q      <= 4'b0000;
         hold_q     <= '0;
         last_two_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         disp_q     <= disp_d;
         dig_q      <= dig_d;
         hold_q     <= hold_d;
         last_two_q <= last_two_d;
      end
   end

   assign grant    = grant_q;
   assign disp_num = disp_q;
   assign dig_en   = dig_q;

endmodule
